mem_port_arbiter: RTL and testbench

- Shares the single 128-bit line-wide memory port between the instruction-cache refill path (I side) and the data-cache refill/write-back path (D side).
- Both sides use the same valid/ready line protocol as the icache memory interface.
- Round-robin arbitration with a registered request latch, one in-flight transaction at a time, and a response-timeout watchdog.
- Sits between the icache/dcache memory ports and the memory/bus bridge.

---
 rtl/mem_port_arbiter_if.sv | 73 +++++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Line-wide memory port bundle shared by the I/D refill paths and the bus bridge.
// The slave view belongs to the arbiter; the master view drives it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] i_rw_addr_i;
  logic              i_rw_req_i;
  logic              i_rw_valid_i;
  logic [LINE_W-1:0] i_data_read_o;
  logic              i_rw_ready_o;

  logic [ADDR_W-1:0] d_rw_addr_i;
  logic              d_rw_req_i;
  logic              d_rw_valid_i;
  logic [LINE_W-1:0] d_data_write_i;
  logic [LINE_W-1:0] d_data_read_o;
  logic              d_rw_ready_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_req_o;
  logic              mem_valid_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  logic [1:0]        grant_o;
  logic              timeout_o;

  modport slave (
    input  i_rw_addr_i,
    input  i_rw_req_i,
    input  i_rw_valid_i,
    output i_data_read_o,
    output i_rw_ready_o,
    input  d_rw_addr_i,
    input  d_rw_req_i,
    input  d_rw_valid_i,
    input  d_data_write_i,
    output d_data_read_o,
    output d_rw_ready_o,
    output mem_addr_o,
    output mem_req_o,
    output mem_valid_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ready_i,
    output grant_o,
    output timeout_o
  );

  modport master (
    output i_rw_addr_i,
    output i_rw_req_i,
    output i_rw_valid_i,
    input  i_data_read_o,
    input  i_rw_ready_o,
    output d_rw_addr_i,
    output d_rw_req_i,
    output d_rw_valid_i,
    output d_data_write_i,
    input  d_data_read_o,
    input  d_rw_ready_o,
    input  mem_addr_o,
    input  mem_req_o,
    input  mem_valid_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ready_i,
    input  grant_o,
    input  timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I and D refill.
// One transaction in flight; sticky watchdog flags a stalled memory response.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t            state, state_nx;
  logic              last_d, last_d_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              req_q, req_nx;
  logic [LINE_W-1:0] wdata_q, wdata_nx;
  logic              valid_q, valid_nx;
  logic [1:0]        grant_q, grant_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic              to_q, to_nx;

  logic pick_i;
  logic pick_d;
  logic busy;
  logic unused_rw;

  // The I side is read-only, so its rw flag carries no information.
  assign unused_rw = bus.i_rw_req_i;

  // Tie goes to whichever side did not own the port last.
  assign pick_i = bus.i_rw_valid_i &
                  (~bus.d_rw_valid_i | last_d);
  assign pick_d = bus.d_rw_valid_i &
                  (~bus.i_rw_valid_i | ~last_d);

  assign busy = (state == BUSY_I) |
                (state == BUSY_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      addr_q  <= '0;
      req_q   <= 1'b0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      last_d  <= last_d_nx;
      addr_q  <= addr_nx;
      req_q   <= req_nx;
      wdata_q <= wdata_nx;
      valid_q <= valid_nx;
      grant_q <= grant_nx;
      cnt_q   <= cnt_nx;
      to_q    <= to_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    last_d_nx = last_d;
    addr_nx   = addr_q;
    req_nx    = req_q;
    wdata_nx  = wdata_q;
    valid_nx  = valid_q;
    grant_nx  = grant_q;
    cnt_nx    = cnt_q;
    to_nx     = to_q;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_i: begin
            state_nx = BUSY_I;
            addr_nx  = bus.i_rw_addr_i;
            req_nx   = 1'b0;
            wdata_nx = '0;
            valid_nx = 1'b1;
            grant_nx = 2'b01;
            cnt_nx   = '0;
          end
          pick_d: begin
            state_nx = BUSY_D;
            addr_nx  = bus.d_rw_addr_i;
            req_nx   = bus.d_rw_req_i;
            wdata_nx = bus.d_data_write_i;
            valid_nx = 1'b1;
            grant_nx = 2'b10;
            cnt_nx   = '0;
          end
          default: ;
        endcase
      end

      BUSY_I, BUSY_D: begin
        if (bus.mem_ready_i) begin
          state_nx  = DONE;
          valid_nx  = 1'b0;
          grant_nx  = 2'b00;
          last_d_nx = (state == BUSY_D);
          cnt_nx    = '0;
        end else if (TIMEOUT != 0 && cnt_q != TMAX) begin
          cnt_nx = cnt_q + 1'b1;
          if (cnt_nx == TMAX) begin
            to_nx = 1'b1;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_valid_o = valid_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.grant_o     = grant_q;
  assign bus.timeout_o   = to_q;

  assign bus.i_rw_ready_o = busy & (state == BUSY_I) &
                            bus.mem_ready_i;
  assign bus.d_rw_ready_o = busy & (state == BUSY_D) &
                            bus.mem_ready_i;

  assign bus.i_data_read_o = grant_q[0] ?
                             bus.mem_rdata_i : '0;
  assign bus.d_data_read_o = grant_q[1] ?
                             bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model plus
// per-cycle compare and literal spot checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TMO = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(64), .LINE_W(128)) bus ();

  mem_port_arbiter #(
    .ADDR_W (64),
    .LINE_W (128),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: owner 0=none 1=I 2=D
  int          m_own;
  bit          m_cool;
  int          m_last;
  int          m_wait;
  bit          m_to;
  logic [63:0]  m_addr;
  bit          m_req;
  logic [127:0] m_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = 0; m_cool = 0; m_last = 2; m_wait = 0;
      m_to = 0; m_addr = '0; m_req = 0; m_wdata = '0;
    end else if (m_own != 0) begin
      if (bus.mem_ready_i) begin
        m_last = m_own; m_own = 0; m_cool = 1; m_wait = 0;
      end else if (m_wait < TMO) begin
        m_wait++;
        if (m_wait == TMO) m_to = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      int who;
      who = 0;
      if (bus.i_rw_valid_i && bus.d_rw_valid_i)
        who = (m_last == 1) ? 2 : 1;
      else if (bus.i_rw_valid_i) who = 1;
      else if (bus.d_rw_valid_i) who = 2;
      if (who == 1) begin
        m_own = 1; m_addr = bus.i_rw_addr_i;
        m_req = 0; m_wdata = '0;
      end else if (who == 2) begin
        m_own = 2; m_addr = bus.d_rw_addr_i;
        m_req = bus.d_rw_req_i; m_wdata = bus.d_data_write_i;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] g;
      bit rdy;
      g = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      rdy = bus.mem_ready_i;
      chk("mem_valid", 128'(bus.mem_valid_o), 128'(m_own != 0));
      chk("grant", 128'(bus.grant_o), 128'(g));
      chk("mem_addr", 128'(bus.mem_addr_o), 128'(m_addr));
      chk("mem_req", 128'(bus.mem_req_o), 128'(m_req));
      chk("mem_wdata", bus.mem_wdata_o, m_wdata);
      chk("i_ready", 128'(bus.i_rw_ready_o),
          128'(m_own == 1 && rdy));
      chk("d_ready", 128'(bus.d_rw_ready_o),
          128'(m_own == 2 && rdy));
      chk("i_data", bus.i_data_read_o,
          (m_own == 1) ? bus.mem_rdata_i : 128'h0);
      if (!(m_own == 2 && m_req && rdy))
        chk("d_data", bus.d_data_read_o,
            (m_own == 2) ? bus.mem_rdata_i : 128'h0);
      chk("timeout", 128'(bus.timeout_o), 128'(m_to));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  localparam logic [127:0] RD1 =
    128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] WD1 =
    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_rw_addr_i = '0; bus.i_rw_req_i = 0;
    bus.i_rw_valid_i = 0;
    bus.d_rw_addr_i = '0; bus.d_rw_req_i = 0;
    bus.d_rw_valid_i = 0; bus.d_data_write_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 0;

    #2;
    chk("rst_valid", 128'(bus.mem_valid_o), 128'h0);
    chk("rst_grant", 128'(bus.grant_o), 128'h0);
    chk("rst_timeout", 128'(bus.timeout_o), 128'h0);
    chk("rst_addr", 128'(bus.mem_addr_o), 128'h0);
    chk("rst_wdata", bus.mem_wdata_o, 128'h0);
    step(); step();
    rst = 1'b0;

    // I-only read
    step();
    bus.i_rw_valid_i = 1; bus.i_rw_addr_i = 64'h8000_0000;
    step(); #1;
    chk("t1_grant", 128'(bus.grant_o), 128'h1);
    chk("t1_valid", 128'(bus.mem_valid_o), 128'h1);
    chk("t1_req", 128'(bus.mem_req_o), 128'h0);
    chk("t1_addr", 128'(bus.mem_addr_o), 128'h8000_0000);
    step();
    step();
    bus.mem_ready_i = 1; bus.mem_rdata_i = RD1; #1;
    chk("t1_iready", 128'(bus.i_rw_ready_o), 128'h1);
    chk("t1_idata", bus.i_data_read_o, RD1);
    chk("t1_dready", 128'(bus.d_rw_ready_o), 128'h0);
    step();
    bus.mem_ready_i = 0; bus.i_rw_valid_i = 0; #1;
    chk("t1_drop", 128'(bus.mem_valid_o), 128'h0);
    idle(3);

    // Simultaneous after reset, then alternation
    rst = 1; step(); rst = 0;
    step();
    bus.i_rw_valid_i = 1; bus.i_rw_addr_i = 64'h100;
    bus.d_rw_valid_i = 1; bus.d_rw_addr_i = 64'h200;
    step(); #1;
    chk("t2_first", 128'(bus.grant_o), 128'h1);
    bus.mem_ready_i = 1; bus.mem_rdata_i = 128'h11; #1;
    chk("t2_iready", 128'(bus.i_rw_ready_o), 128'h1);
    step();
    bus.mem_ready_i = 0; bus.i_rw_addr_i = 64'h300; #1;
    chk("t2_done", 128'(bus.grant_o), 128'h0);
    step();
    step(); #1;
    chk("t2_second", 128'(bus.grant_o), 128'h2);
    chk("t2_daddr", 128'(bus.mem_addr_o), 128'h200);
    bus.mem_ready_i = 1; bus.mem_rdata_i = 128'h22; #1;
    chk("t2_dready", 128'(bus.d_rw_ready_o), 128'h1);
    chk("t2_iquiet", 128'(bus.i_rw_ready_o), 128'h0);
    step();
    bus.mem_ready_i = 0; bus.d_rw_valid_i = 0;
    step();
    step(); #1;
    chk("t2_third", 128'(bus.grant_o), 128'h1);
    chk("t2_iaddr", 128'(bus.mem_addr_o), 128'h300);
    bus.mem_ready_i = 1;
    step();
    bus.mem_ready_i = 0; bus.i_rw_valid_i = 0;
    idle(3);

    // D write
    bus.d_rw_valid_i = 1; bus.d_rw_req_i = 1;
    bus.d_rw_addr_i = 64'h8000_1000; bus.d_data_write_i = WD1;
    step(); #1;
    chk("t3_grant", 128'(bus.grant_o), 128'h2);
    chk("t3_req", 128'(bus.mem_req_o), 128'h1);
    chk("t3_wdata", bus.mem_wdata_o, WD1);
    step();
    bus.mem_ready_i = 1; #1;
    chk("t3_dready", 128'(bus.d_rw_ready_o), 128'h1);
    chk("t3_iready", 128'(bus.i_rw_ready_o), 128'h0);
    step();
    bus.mem_ready_i = 0; bus.d_rw_valid_i = 0;
    bus.d_rw_req_i = 0;
    idle(3);

    // Stale valid held through DONE
    bus.i_rw_valid_i = 1; bus.i_rw_addr_i = 64'h440;
    step();
    bus.mem_ready_i = 1;
    step();
    bus.mem_ready_i = 0;
    step();
    bus.i_rw_valid_i = 0; #1;
    chk("t4_nogrant", 128'(bus.mem_valid_o), 128'h0);
    step(); #1;
    chk("t4_idle", 128'(bus.mem_valid_o), 128'h0);
    bus.i_rw_valid_i = 1;
    step(); #1;
    chk("t4_regrant", 128'(bus.grant_o), 128'h1);
    bus.mem_ready_i = 1;
    step();
    bus.mem_ready_i = 0; bus.i_rw_valid_i = 0;
    idle(3);

    // Watchdog
    bus.i_rw_valid_i = 1; bus.i_rw_addr_i = 64'h880;
    idle(8); #1;
    chk("t5_before", 128'(bus.timeout_o), 128'h0);
    step(); #1;
    chk("t5_set", 128'(bus.timeout_o), 128'h1);
    chk("t5_wait", 128'(bus.mem_valid_o), 128'h1);
    idle(3);
    bus.mem_ready_i = 1; bus.mem_rdata_i = 128'h55; #1;
    chk("t5_iready", 128'(bus.i_rw_ready_o), 128'h1);
    step();
    bus.mem_ready_i = 0; bus.i_rw_valid_i = 0; #1;
    chk("t5_sticky", 128'(bus.timeout_o), 128'h1);
    idle(3);

    // Async reset mid-BUSY
    bus.d_rw_valid_i = 1; bus.d_rw_addr_i = 64'h990;
    step();
    step(); #2;
    rst = 1; #1;
    chk("t6_valid", 128'(bus.mem_valid_o), 128'h0);
    chk("t6_grant", 128'(bus.grant_o), 128'h0);
    chk("t6_timeout", 128'(bus.timeout_o), 128'h0);
    bus.d_rw_valid_i = 0;
    step();
    rst = 0;
    bus.i_rw_valid_i = 1; bus.d_rw_valid_i = 1;
    step(); #1;
    chk("t6_tie", 128'(bus.grant_o), 128'h1);
    bus.mem_ready_i = 1;
    step();
    bus.mem_ready_i = 0; bus.i_rw_valid_i = 0;
    bus.d_rw_valid_i = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
